// File: rtl/wallace_csa_pipe.sv
// wallace_csa_pipe: pipelined 3:2 CSA tree that reduces ROWS partial products
// to a redundant sum/carry pair. A pipeline register sits after every
// LEVELS_PER_REG CSA levels, and one global advance enable gives full backpressure.
// Optional macro WALLACE_FINAL_ADD_EN adds a registered carry-propagate
// stage that drives res_out. Without it, res_out is tied to 0.
module wallace_csa_pipe #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned ROWS           = 16,
  parameter int unsigned LEVELS_PER_REG = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*WIDTH-1:0]  pp_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum_out,
  output logic [WIDTH-1:0]       carry_out,
  output logic [WIDTH-1:0]       res_out
);

  // Row count after one 3:2 level: each full triple becomes two rows, leftovers pass.
  function automatic int unsigned next_rows(input int unsigned n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int unsigned rows_at(input int unsigned lvl);
    int unsigned n;
    n = ROWS;
    for (int unsigned i = 0; i < lvl; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int unsigned num_levels();
    int unsigned n;
    int unsigned l;
    n = ROWS;
    l = 0;
    while (n > 2 && l < 64) begin
      n = next_rows(n);
      l++;
    end
    return (l == 0) ? 1 : l;
  endfunction

  localparam int unsigned LPR  = (LEVELS_PER_REG == 0) ? 1 : LEVELS_PER_REG;
  localparam int unsigned NLVL = num_levels();
  localparam int unsigned NSTG = (NLVL + LPR - 1) / LPR;
`ifdef WALLACE_FINAL_ADD_EN
  localparam int unsigned NVLD = NSTG + 1;
`else
  localparam int unsigned NVLD = NSTG;
`endif

  typedef logic [ROWS-1:0][WIDTH-1:0] rows_t;

  // Reject illegal configurations at elaboration.
  if (ROWS < 3 || ROWS > 32 || LEVELS_PER_REG < 1) begin : g_param_check
    $error("wallace_csa_pipe: ROWS must be 3..32 and LEVELS_PER_REG >= 1");
  end

  logic [NVLD-1:0] r_valid;
  logic            w_adv;

  assign out_valid = r_valid[NVLD-1];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv && !flush && !rst;

  // Valid bits shift as a unit on advance. Bubbles are kept, and flush/reset clear them all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= NVLD'({r_valid, in_valid});
    end
  end

  // CSA levels. A level starts a new pipeline stage every LPR levels.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int unsigned N   = rows_at(l);
    localparam int unsigned STG = l / LPR;
    rows_t w_in;
    rows_t w_out;

    if (l % LPR == 0) begin : g_src
      if (l == 0) begin : g_first
        assign w_in = pp_in;
      end else begin : g_reg
        assign w_in = g_stg[STG-1].r_data;
      end
    end else begin : g_chain
      assign w_in = g_lvl[l-1].w_out;
    end

    // Full adders across each triple, with the carry shifted up and bit WIDTH dropped.
    always_comb begin
      w_out = '0;
      for (int unsigned g = 0; g < N / 3; g++) begin
        w_out[2*g]   = w_in[3*g] ^ w_in[3*g+1] ^ w_in[3*g+2];
        w_out[2*g+1] = ((w_in[3*g] & w_in[3*g+1]) |
                        (w_in[3*g] & w_in[3*g+2]) |
                        (w_in[3*g+1] & w_in[3*g+2])) << 1;
      end
      for (int unsigned k = 0; k < N % 3; k++) begin
        w_out[2*(N/3)+k] = w_in[3*(N/3)+k];
      end
    end

    if (N < ROWS) begin : g_pad
      logic w_unused_rows;
      assign w_unused_rows = ^w_in[ROWS-1:N];
    end
  end

  // Pipeline data registers. They hold on stall and on flush, and clear on reset.
  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int unsigned LAST = ((s + 1) * LPR < NLVL) ? (s + 1) * LPR - 1 : NLVL - 1;
    rows_t r_data;

    // Capture the output of this stage's last CSA level on advance.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= '0;
      end else if (w_adv && !flush) begin
        r_data <= g_lvl[LAST].w_out;
      end
    end
  end

  logic w_unused_tail;
  assign w_unused_tail = ^g_stg[NSTG-1].r_data[ROWS-1:2];

`ifdef WALLACE_FINAL_ADD_EN
  logic [WIDTH-1:0] r_fa_sum;
  logic [WIDTH-1:0] r_fa_carry;
  logic [WIDTH-1:0] r_fa_res;

  // Final carry-propagate stage, with sum/carry copies aligned to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fa_sum   <= '0;
      r_fa_carry <= '0;
      r_fa_res   <= '0;
    end else if (w_adv && !flush) begin
      r_fa_sum   <= g_stg[NSTG-1].r_data[0];
      r_fa_carry <= g_stg[NSTG-1].r_data[1];
      r_fa_res   <= g_stg[NSTG-1].r_data[0] + g_stg[NSTG-1].r_data[1];
    end
  end

  assign sum_out   = r_fa_sum;
  assign carry_out = r_fa_carry;
  assign res_out   = r_fa_res;
`else
  assign sum_out   = g_stg[NSTG-1].r_data[0];
  assign carry_out = g_stg[NSTG-1].r_data[1];
  assign res_out   = '0;
`endif

endmodule
